// File: rtl/fetch_addr_gen.sv
// Fetch program counter plus a first-word-fall-through address FIFO feeding the fetch stage.
// Jump or JTAG reset flushes all queued addresses and restarts the sequential stream.
module fetch_addr_gen #(
  parameter int          DEPTH    = 8,
  parameter int          PTR_W    = 3,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jtag_reset_flag_i,
  input  logic             jump_flag_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             hold_flag_i,
  input  logic             addr_fifo_ren,
  output logic [31:0]      addr_fifo_r,
  output logic             addr_fifo_empty,
  output logic             addr_fifo_full,
  output logic [PTR_W:0]   addr_fifo_count,
  output logic [31:0]      pc_o
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      mem_d [DEPTH];
  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;

  assign addr_fifo_empty = (count_q == '0);
  assign addr_fifo_full  = (count_q == DEPTH_C);
  assign addr_fifo_count = count_q;
  assign addr_fifo_r     = mem_q[rptr_q];
  assign pc_o            = pc_q;

  always_comb begin
    pc_d    = pc_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    mem_d   = mem_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (jump_flag_i) begin
      // redirect flushes the queue; any pop strobe this cycle is dropped
      pc_d    = {jump_addr_i[31:2], 2'b00};
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      push = ~addr_fifo_full & ~hold_flag_i;
      pop  = addr_fifo_ren & ~addr_fifo_empty;
      if (push) begin
        mem_d[wptr_q] = pc_q;
        wptr_d        = wptr_q + PTR_W'(1);
        pc_d          = pc_q + 32'd4;
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + (PTR_W+1)'(1);
      end else if (pop && !push) begin
        count_d = count_q - (PTR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || jtag_reset_flag_i) begin
      pc_q    <= RESET_PC & ~32'h3;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_fetch_addr_gen.sv
// Scoreboard bench for fetch_addr_gen: a queue-based model predicts the issued address
// stream and occupancy; a negedge monitor checks every pop and the status outputs.
module tb_fetch_addr_gen;

  localparam int          DEPTH    = 8;
  localparam int          PTR_W    = 3;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             jtag_reset_flag_i = 1'b0;
  logic             jump_flag_i = 1'b0;
  logic [31:0]      jump_addr_i = '0;
  logic             hold_flag_i = 1'b0;
  logic             addr_fifo_ren = 1'b0;
  logic [31:0]      addr_fifo_r;
  logic             addr_fifo_empty;
  logic             addr_fifo_full;
  logic [PTR_W:0]   addr_fifo_count;
  logic [31:0]      pc_o;

  fetch_addr_gen #(.DEPTH(DEPTH), .PTR_W(PTR_W), .RESET_PC(RESET_PC)) dut (
    .clk               (clk),
    .rst               (rst),
    .jtag_reset_flag_i (jtag_reset_flag_i),
    .jump_flag_i       (jump_flag_i),
    .jump_addr_i       (jump_addr_i),
    .hold_flag_i       (hold_flag_i),
    .addr_fifo_ren     (addr_fifo_ren),
    .addr_fifo_r       (addr_fifo_r),
    .addr_fifo_empty   (addr_fifo_empty),
    .addr_fifo_full    (addr_fifo_full),
    .addr_fifo_count   (addr_fifo_count),
    .pc_o              (pc_o)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];
  logic [31:0] m_pc = '0;
  int          m_count = 0;
  bit          m_live = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: next address is previous + 4; queue bounded at DEPTH entries
  always @(posedge clk) begin
    if (rst || jtag_reset_flag_i) begin
      m_pc    = RESET_PC;
      m_count = 0;
      sb_q.delete();
      m_live  = 1'b1;
    end else if (m_live) begin
      if (jump_flag_i) begin
        m_pc    = jump_addr_i & 32'hFFFF_FFFC;
        m_count = 0;
        sb_q.delete();
      end else begin
        bit do_push, do_pop;
        do_push = (m_count < DEPTH) && !hold_flag_i;
        do_pop  = addr_fifo_ren && (m_count > 0);
        if (do_push) begin
          sb_q.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
        m_count = m_count + int'(do_push) - int'(do_pop);
      end
    end
  end

  // monitor: the head address is consumed on the coming edge when ren is high and data is queued
  always @(negedge clk) begin
    if (m_live && !rst && !jtag_reset_flag_i) begin
      chk("count", 32'(addr_fifo_count), 32'(m_count));
      chk("empty", 32'(addr_fifo_empty), 32'(m_count == 0));
      chk("full",  32'(addr_fifo_full),  32'(m_count == DEPTH));
      chk("pc_o",  pc_o, m_pc);
      if (addr_fifo_ren && !jump_flag_i && m_count > 0) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL scoreboard: pop with no expected address at %0t", $time);
        end else begin
          chk("addr_fifo_r", addr_fifo_r, sb_q.pop_front());
        end
      end
    end
  end

  task automatic drive(bit r, bit jt, bit jp, logic [31:0] ja, bit h, bit rn, int n);
    for (int i = 0; i < n; i++) begin
      rst               = r;
      jtag_reset_flag_i = jt;
      jump_flag_i       = jp;
      jump_addr_i       = ja;
      hold_flag_i       = h;
      addr_fifo_ren     = rn;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // reset then fill with no consumer
    drive(1, 0, 0, '0, 0, 0, 2);
    chk("rst_empty", 32'(addr_fifo_empty), 32'd1);
    chk("rst_count", 32'(addr_fifo_count), 32'd0);
    chk("rst_pc", pc_o, RESET_PC);
    drive(0, 0, 0, '0, 0, 0, 10);
    chk("fill_pc", pc_o, 32'h20);
    chk("fill_full", 32'(addr_fifo_full), 32'd1);
    drive(0, 0, 0, '0, 0, 1, 8);
    drive(0, 0, 0, '0, 0, 0, 2);

    // mid-stream jump with count = 5
    drive(1, 0, 0, '0, 0, 0, 1);
    drive(0, 0, 0, '0, 0, 0, 5);
    drive(0, 0, 1, 32'h0000_1002, 0, 0, 1);
    chk("jump_empty", 32'(addr_fifo_empty), 32'd1);
    chk("jump_pc", pc_o, 32'h1000);
    drive(0, 0, 0, '0, 0, 0, 1);
    chk("jump_head", addr_fifo_r, 32'h1000);
    chk("jump_count", 32'(addr_fifo_count), 32'd1);
    drive(0, 0, 0, '0, 0, 1, 3);

    // jump held three cycles with ren high
    drive(0, 0, 1, 32'h0000_2000, 0, 1, 1);
    drive(0, 0, 1, 32'h0000_3005, 0, 1, 1);
    drive(0, 0, 1, 32'h0000_400B, 0, 1, 1);
    drive(0, 0, 0, '0, 0, 0, 1);
    chk("held_jump_head", addr_fifo_r, 32'h4008);
    drive(0, 0, 0, '0, 0, 1, 4);

    // hold with ren high starting from count = 3
    drive(1, 0, 0, '0, 0, 0, 1);
    drive(0, 0, 0, '0, 0, 0, 3);
    drive(0, 0, 0, '0, 1, 1, 4);
    chk("hold_count", 32'(addr_fifo_count), 32'd0);
    chk("hold_pc", pc_o, 32'h0C);
    drive(0, 0, 0, '0, 0, 1, 4);

    // wrap past the top of the address space, then JTAG reset
    drive(0, 0, 1, 32'hFFFF_FFF8, 0, 0, 1);
    drive(0, 0, 0, '0, 0, 0, 3);
    drive(0, 0, 0, '0, 0, 1, 5);
    drive(0, 1, 0, '0, 0, 1, 1);
    chk("jtag_pc", pc_o, RESET_PC);
    chk("jtag_empty", 32'(addr_fifo_empty), 32'd1);
    drive(0, 0, 0, '0, 0, 0, 2);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic [31:0] ja;
      bit jp, jt, h, rn;
      jt = ($urandom_range(0, 99) < 2);
      jp = ($urandom_range(0, 99) < 6);
      h  = ($urandom_range(0, 99) < 20);
      rn = ($urandom_range(0, 99) < 55);
      ja = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      drive(0, jt, jp, ja, h, rn, 1);
    end
    drive(0, 0, 0, '0, 0, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
